// File: rtl/idct_block.sv
// rtl/idct_block.sv - 8x8 three-channel inverse DCT, one multiply-accumulate term per cycle
//
// Collects a block of 64 coefficient triples, then computes every pixel of
// the block as a 64-term sum. Each pixel is presented on the output stream
// and held until it is accepted.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   in_valid, in_ready                  input handshake; a triple moves when both are high
//   Y_in, Cr_in, Cb_in                  signed 14-bit coefficients, block order n = 8*v+u
//   out_valid, out_ready                output handshake; a pixel moves when both are high
//   Y_out, Cr_out, Cb_out               unsigned 8-bit pixels
//   out_index                           pixel position 8*y+x
//   out_last                            high with pixel 63

module idct_block (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [13:0] Y_in,
  input  logic signed [13:0] Cr_in,
  input  logic signed [13:0] Cb_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        Y_out,
  output logic [7:0]        Cr_out,
  output logic [7:0]        Cb_out,
  output logic [5:0]        out_index,
  output logic              out_last
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // n: coefficient being loaded, p: pixel being computed, k: term within pixel
  logic [5:0] n_cnt;
  logic [5:0] p_cnt;
  logic [5:0] k_cnt;

  // Coefficient storage; contents are don't-care until a block is loaded
  logic signed [13:0] y_mem  [64];
  logic signed [13:0] cr_mem [64];
  logic signed [13:0] cb_mem [64];

  // Worst case |sum| is about 2^33, so 40 bits cannot overflow
  logic signed [39:0] acc_y;
  logic signed [39:0] acc_cr;
  logic signed [39:0] acc_cb;
  logic signed [39:0] sum_y;
  logic signed [39:0] sum_cr;
  logic signed [39:0] sum_cb;

  logic [2:0]        freq_u;
  logic [2:0]        freq_v;
  logic [2:0]        pix_x;
  logic [2:0]        pix_y;
  logic [4:0]        ang_x;
  logic [4:0]        ang_y;
  logic signed [5:0] cos_x;
  logic signed [5:0] cos_y;
  logic [7:0]        weight;
  logic              load_fire;
  logic              last_term;

  // Q4 cosine over a 32-step period; the table stores 0..16 and the upper
  // half mirrors it, so 32-a (mod 32) folds back into range.
  function automatic logic signed [5:0] cos_q4(input logic [4:0] ang);
    logic [4:0] fold;
    fold = (ang > 5'd16) ? (5'd0 - ang) : ang;
    case (fold)
      5'd0:    cos_q4 = 6'sd16;
      5'd1:    cos_q4 = 6'sd15;
      5'd2:    cos_q4 = 6'sd14;
      5'd3:    cos_q4 = 6'sd13;
      5'd4:    cos_q4 = 6'sd11;
      5'd5:    cos_q4 = 6'sd8;
      5'd6:    cos_q4 = 6'sd6;
      5'd7:    cos_q4 = 6'sd3;
      5'd8:    cos_q4 = 6'sd0;
      5'd9:    cos_q4 = -6'sd3;
      5'd10:   cos_q4 = -6'sd6;
      5'd11:   cos_q4 = -6'sd8;
      5'd12:   cos_q4 = -6'sd11;
      5'd13:   cos_q4 = -6'sd13;
      5'd14:   cos_q4 = -6'sd14;
      5'd15:   cos_q4 = -6'sd15;
      5'd16:   cos_q4 = -6'sd16;
      default: cos_q4 = 6'sd0;
    endcase
  endfunction

  // coef * cx * cy * w, each stage sized to its exact signed range
  function automatic logic signed [39:0] idct_term(
    input logic signed [13:0] coef,
    input logic signed [5:0]  cx,
    input logic signed [5:0]  cy,
    input logic [7:0]         w
  );
    logic signed [19:0] p1;
    logic signed [25:0] p2;
    logic signed [33:0] p3;
    p1 = $signed({{6{coef[13]}}, coef}) * $signed({{14{cx[5]}}, cx});
    p2 = $signed({{6{p1[19]}}, p1}) * $signed({{20{cy[5]}}, cy});
    p3 = $signed({{8{p2[25]}}, p2}) * $signed({26'd0, w});
    return $signed({{6{p3[33]}}, p3});
  endfunction

  // Remove the Q4*Q4*Q8 scale with rounding (arithmetic shift floors
  // negatives), then saturate into the 8-bit pixel range.
  function automatic logic [7:0] to_pixel(input logic signed [39:0] acc);
    logic signed [39:0] r;
    r = (acc + 40'sd32768) >>> 16;
    if (r < 40'sd0) begin
      to_pixel = 8'd0;
    end else if (r > 40'sd255) begin
      to_pixel = 8'd255;
    end else begin
      to_pixel = r[7:0];
    end
  endfunction

  // Term datapath
  always_comb begin
    freq_u    = k_cnt[2:0];
    freq_v    = k_cnt[5:3];
    pix_x     = p_cnt[2:0];
    pix_y     = p_cnt[5:3];
    // (2x+1)*u truncated to 5 bits is the mod-32 angle index
    ang_x     = {1'b0, pix_x, 1'b1} * {2'b00, freq_u};
    ang_y     = {1'b0, pix_y, 1'b1} * {2'b00, freq_v};
    cos_x     = cos_q4(ang_x);
    cos_y     = cos_q4(ang_y);
    if (freq_u == 3'd0 && freq_v == 3'd0) begin
      weight = 8'd32;
    end else if (freq_u == 3'd0 || freq_v == 3'd0) begin
      weight = 8'd45;
    end else begin
      weight = 8'd64;
    end
    sum_y     = acc_y  + idct_term(y_mem[k_cnt],  cos_x, cos_y, weight);
    sum_cr    = acc_cr + idct_term(cr_mem[k_cnt], cos_x, cos_y, weight);
    sum_cb    = acc_cb + idct_term(cb_mem[k_cnt], cos_x, cos_y, weight);
    last_term = (k_cnt == 6'd63);
    load_fire = (state == LOAD) && in_valid && !reset;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && n_cnt == 6'd63) begin
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (last_term) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = (p_cnt == 6'd63) ? LOAD : COMPUTE;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Coefficient write port
  always_ff @(posedge clk) begin
    if (load_fire) begin
      y_mem[n_cnt]  <= Y_in;
      cr_mem[n_cnt] <= Cr_in;
      cb_mem[n_cnt] <= Cb_in;
    end
  end

  // Counters, accumulators and registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      n_cnt     <= 6'd0;
      p_cnt     <= 6'd0;
      k_cnt     <= 6'd0;
      acc_y     <= 40'sd0;
      acc_cr    <= 40'sd0;
      acc_cb    <= 40'sd0;
      Y_out     <= 8'd0;
      Cr_out    <= 8'd0;
      Cb_out    <= 8'd0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            // n wraps to 0 after the 64th triple, ready for the next block
            n_cnt <= n_cnt + 6'd1;
            if (n_cnt == 6'd63) begin
              p_cnt  <= 6'd0;
              k_cnt  <= 6'd0;
              acc_y  <= 40'sd0;
              acc_cr <= 40'sd0;
              acc_cb <= 40'sd0;
            end
          end
        end
        COMPUTE: begin
          k_cnt <= k_cnt + 6'd1;
          if (last_term) begin
            // The final sum goes straight to the pixel registers, so the
            // accumulators can be cleared on the same edge.
            Y_out     <= to_pixel(sum_y);
            Cr_out    <= to_pixel(sum_cr);
            Cb_out    <= to_pixel(sum_cb);
            out_index <= p_cnt;
            out_last  <= (p_cnt == 6'd63);
            acc_y     <= 40'sd0;
            acc_cr    <= 40'sd0;
            acc_cb    <= 40'sd0;
          end else begin
            acc_y  <= sum_y;
            acc_cr <= sum_cr;
            acc_cb <= sum_cb;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            k_cnt  <= 6'd0;
            acc_y  <= 40'sd0;
            acc_cr <= 40'sd0;
            acc_cb <= 40'sd0;
            if (p_cnt == 6'd63) begin
              p_cnt <= 6'd0;
              n_cnt <= 6'd0;
            end else begin
              p_cnt <= p_cnt + 6'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
